// File: rtl/rx_receiver.sv
// Serial frame receiver: start bit, DATA_W bits LSB first, optional even parity, stop bit.
// Optional parity bit and PARITY state are built when RX_PARITY_EN is defined.
module rx_receiver #(
   parameter int DATA_W = 55
) (
   input  logic              Clk_S,
   input  logic              Rst,
   input  logic              S_Data,
   input  logic              RX_Ready,
   output logic [DATA_W-1:0] RX_Data,
   output logic              RX_Data_Valid,
   output logic              Frame_Err
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DATA   = 3'd1,
`ifdef RX_PARITY_EN
      S_PARITY = 3'd2,
`endif
      S_STOP   = 3'd3,
      S_HOLD   = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  shift_q;
   logic [DATA_W-1:0]  rx_data_q;
   logic               rx_valid_q;
   logic               frame_err_q;
   logic               parity_ok;
   logic               shift_en;
   logic               word_load;
   logic               word_err;
   logic               word_xfer;

   // NOTE: every signal written here gets a default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_en  = 1'b0;
      word_load = 1'b0;
      word_err  = 1'b0;
      word_xfer = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!S_Data) begin
               state_d = S_DATA;
               cnt_d   = '0;
            end
         end
         S_DATA: begin
            shift_en = 1'b1;
            if (cnt_q == LAST_BIT) begin
`ifdef RX_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_STOP;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`ifdef RX_PARITY_EN
         S_PARITY: state_d = S_STOP;
`endif
         S_STOP: begin
            if (S_Data && parity_ok) begin
               word_load = 1'b1;
               state_d   = S_HOLD;
            end else begin
               word_err = 1'b1;
               state_d  = S_IDLE;
            end
         end
         // The line is deliberately ignored while a word waits for its consumer.
         S_HOLD: begin
            if (RX_Ready) begin
               word_xfer = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge Clk_S) begin
      if (Rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         frame_err_q <= word_err;
         if (word_load) begin
            rx_data_q  <= shift_q;
            rx_valid_q <= 1'b1;
         end else if (word_xfer) begin
            rx_valid_q <= 1'b0;
         end
      end
   end

   // NOTE: the shift register has no reset; every bit is rewritten by a frame
   // before it can reach RX_Data.
   always_ff @(posedge Clk_S) begin
      if (shift_en) shift_q[cnt_q] <= S_Data;
   end

`ifdef RX_PARITY_EN
   logic parity_ok_q;

   always_ff @(posedge Clk_S) begin
      if (Rst)                      parity_ok_q <= 1'b1;
      else if (state_q == S_PARITY) parity_ok_q <= (S_Data == ^shift_q);
   end

   assign parity_ok = parity_ok_q;
`else
   assign parity_ok = 1'b1;
`endif

   assign RX_Data       = rx_data_q;
   assign RX_Data_Valid = rx_valid_q;
   assign Frame_Err     = frame_err_q;

endmodule

// File: tb/tb_rx_receiver.sv
// Directed bench for rx_receiver: idle, handshake, hold, stop/parity errors, reset abort.
module tb_rx_receiver;

   localparam int W = 55;

   logic          Clk_S = 1'b0;
   logic          Rst;
   logic          S_Data;
   logic          RX_Ready;
   logic [W-1:0]  RX_Data;
   logic          RX_Data_Valid;
   logic          Frame_Err;

   int n_chk = 0;
   int n_bad = 0;

   rx_receiver #(.DATA_W(W)) dut (
      .Clk_S         (Clk_S),
      .Rst           (Rst),
      .S_Data        (S_Data),
      .RX_Ready      (RX_Ready),
      .RX_Data       (RX_Data),
      .RX_Data_Valid (RX_Data_Valid),
      .Frame_Err     (Frame_Err)
   );

   always #5 Clk_S = ~Clk_S;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Drives one frame; returns at the negedge after the stop bit has been sampled.
   task automatic send_frame(input logic [W-1:0] p, input logic stop_b, input logic par_bad);
      @(negedge Clk_S) S_Data = 1'b0;
      for (int i = 0; i < W; i++) begin
         @(negedge Clk_S) S_Data = p[i];
      end
`ifdef RX_PARITY_EN
      @(negedge Clk_S) S_Data = (^p) ^ par_bad;
`else
      if (par_bad) $display("note: parity not built, flag ignored");
`endif
      @(negedge Clk_S) S_Data = stop_b;
      check("valid_before_stop", {63'd0, RX_Data_Valid}, 64'd0);
      @(negedge Clk_S) S_Data = 1'b1;
   endtask

   initial begin
      int bad_cyc;
      int hold_cnt;

      Rst = 1'b1; S_Data = 1'b1; RX_Ready = 1'b0;
      repeat (3) @(negedge Clk_S);
      Rst = 1'b0;
      check("rst_valid", {63'd0, RX_Data_Valid}, 64'd0);
      check("rst_data",  {9'd0, RX_Data}, 64'd0);
      check("rst_err",   {63'd0, Frame_Err}, 64'd0);

      // Idle line for 20 cycles
      bad_cyc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk_S);
         if (RX_Data_Valid || Frame_Err || RX_Data != '0) bad_cyc++;
      end
      check("idle_quiet", 64'(bad_cyc), 64'd0);

      // Alternating payload, consumer ready
      RX_Ready = 1'b1;
      send_frame(55'h2A_AAAA_AAAA_AAAA, 1'b1, 1'b0);
      check("alt_valid", {63'd0, RX_Data_Valid}, 64'd1);
      check("alt_data",  {9'd0, RX_Data}, 64'h002A_AAAA_AAAA_AAAA);
      check("alt_err",   {63'd0, Frame_Err}, 64'd0);
      @(negedge Clk_S);
      check("alt_one_cycle", {63'd0, RX_Data_Valid}, 64'd0);

      // Back-pressure for 10 cycles; a frame started during HOLD must be lost
      RX_Ready = 1'b0;
      send_frame(55'h1, 1'b1, 1'b0);
      hold_cnt = 0;
      for (int j = 0; j <= 10; j++) begin
         if (j > 0) @(negedge Clk_S);
         if (RX_Data_Valid && RX_Data == 55'h1) hold_cnt++;
         RX_Ready = (j == 10);
         S_Data   = (j == 3) ? 1'b0 : 1'b1;
      end
      @(negedge Clk_S);
      check("hold_cycles", 64'(hold_cnt), 64'd11);
      check("hold_released", {63'd0, RX_Data_Valid}, 64'd0);
      bad_cyc = 0;
      for (int i = 0; i < 70; i++) begin
         @(negedge Clk_S);
         if (RX_Data_Valid || Frame_Err) bad_cyc++;
      end
      check("hold_frame_lost", 64'(bad_cyc), 64'd0);
      check("hold_data_kept", {9'd0, RX_Data}, 64'd1);

      // Bad stop bit
      RX_Ready = 1'b1;
      send_frame(55'h12345, 1'b0, 1'b0);
      check("stop_err",   {63'd0, Frame_Err}, 64'd1);
      check("stop_valid", {63'd0, RX_Data_Valid}, 64'd0);
      check("stop_data",  {9'd0, RX_Data}, 64'd1);
      @(negedge Clk_S);
      check("stop_err_pulse", {63'd0, Frame_Err}, 64'd0);
      check("stop_valid_after", {63'd0, RX_Data_Valid}, 64'd0);

`ifdef RX_PARITY_EN
      send_frame(55'h3, 1'b1, 1'b1);
      check("par_bad_err",   {63'd0, Frame_Err}, 64'd1);
      check("par_bad_valid", {63'd0, RX_Data_Valid}, 64'd0);
      @(negedge Clk_S);
      send_frame(55'h3, 1'b1, 1'b0);
      check("par_ok_valid", {63'd0, RX_Data_Valid}, 64'd1);
      check("par_ok_data",  {9'd0, RX_Data}, 64'd3);
      check("par_ok_err",   {63'd0, Frame_Err}, 64'd0);
      @(negedge Clk_S);
`endif

      // Reset pulse at data bit 30 of a frame, then a clean frame
      @(negedge Clk_S) S_Data = 1'b0;
      for (int i = 0; i <= 30; i++) begin
         @(negedge Clk_S) S_Data = i[0];
      end
      Rst = 1'b1;
      @(negedge Clk_S);
      Rst = 1'b0; S_Data = 1'b1;
      check("abort_data",  {9'd0, RX_Data}, 64'd0);
      check("abort_valid", {63'd0, RX_Data_Valid}, 64'd0);
      bad_cyc = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge Clk_S);
         if (RX_Data_Valid || Frame_Err) bad_cyc++;
      end
      check("abort_quiet", 64'(bad_cyc), 64'd0);
      send_frame(55'h7F, 1'b1, 1'b0);
      check("resume_valid", {63'd0, RX_Data_Valid}, 64'd1);
      check("resume_data",  {9'd0, RX_Data}, 64'h7F);
      check("resume_err",   {63'd0, Frame_Err}, 64'd0);
      @(negedge Clk_S);
      check("resume_one_cycle", {63'd0, RX_Data_Valid}, 64'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/rx_receiver.md
RX_RECEIVER -- requirements
Module: rx_receiver

Interface
REQ-001 Parameter: DATA_W, default 55, payload width in bits per frame.
REQ-002 Port: Clk_S  input  1  serial clock; all state updates on its rising edge.
REQ-003 Port: Rst  input  1  reset, synchronous, active-high.
REQ-004 Port: S_Data  input  1  serial line; idle level 1.
REQ-005 Port: RX_Ready  input  1  consumer can accept a word this cycle.
REQ-006 Port: RX_Data  output  DATA_W  received payload; bit 0 is the first data bit on the line.
REQ-007 Port: RX_Data_Valid  output  1  RX_Data holds an unconsumed word.
REQ-008 Port: Frame_Err  output  1  one-cycle pulse; bad stop bit or bad parity.

Function
REQ-009 Frame format, one bit per Clk_S: start bit (0), DATA_W data bits LSB first, optional parity bit (REQ-024), stop bit (1).
REQ-010 States: IDLE, DATA, PARITY, STOP, HOLD.
REQ-011 IDLE: when S_Data = 0 is sampled, go to DATA and clear the bit counter; otherwise stay in IDLE.
REQ-012 DATA: sample S_Data into shift register position [counter] each cycle; after DATA_W samples, go to PARITY if enabled, else STOP.
REQ-013 PARITY: sample one bit and compare it with the even parity of the shifted payload; go to STOP.
REQ-014 STOP: sample one bit. If it is 1 and parity is OK: load RX_Data, assert RX_Data_Valid next cycle, go to HOLD. Otherwise: pulse Frame_Err, discard the payload, go to IDLE; RX_Data is unchanged.
REQ-015 Latency: RX_Data_Valid rises on the clock edge after the stop bit is sampled; DATA_W+2 cycles after the start bit (DATA_W+3 with parity).
REQ-016 Handshake: a transfer occurs on a cycle where RX_Data_Valid = 1 and RX_Ready = 1. RX_Data_Valid drops on the next edge and the FSM goes to IDLE.
REQ-017 While RX_Data_Valid = 1 and there has been no transfer, RX_Data and RX_Data_Valid stay stable.
REQ-018 HOLD: S_Data is ignored, so a frame that starts during HOLD is lost. No partial capture is allowed.
REQ-019 The line may restart only after the transfer: the first cycle in which a start bit can be detected is the cycle after the transfer edge.
REQ-020 RX_Ready asserted while RX_Data_Valid = 0 has no effect.
REQ-021 The bit counter is DATA_W-range only and never wraps mid-frame. A start bit is not searched for during DATA, PARITY or STOP.

Reset
REQ-022 When Rst = 1 at a rising edge: state becomes IDLE, counter 0, RX_Data_Valid 0, Frame_Err 0, RX_Data all zeros.
REQ-023 Rst asserted mid-frame or in HOLD aborts the frame or word with no Frame_Err. Reception resumes with the first start bit sampled after Rst deasserts.

Configuration
REQ-024 RX_PARITY_EN defined: an even-parity bit follows the data bits, the PARITY state exists, and a parity mismatch produces Frame_Err.
REQ-025 RX_PARITY_EN undefined: no parity bit, the PARITY state is not built, and the frame is DATA_W+2 bits.

Verification
REQ-026 Reset, then line held at 1 for 20 cycles -> RX_Data_Valid = 0, RX_Data = 0, Frame_Err = 0 throughout.
REQ-027 Frame payload 55'h2A_AAAA_AAAA_AAAA, RX_Ready = 1 -> RX_Data_Valid high exactly one cycle; RX_Data = 55'h2A_AAAA_AAAA_AAAA.
REQ-028 Frame payload 55'h1, RX_Ready = 0 for 10 cycles then 1 -> RX_Data_Valid held 11 cycles with RX_Data stable. A second frame started during HOLD is not captured.
REQ-029 Frame with stop bit = 0 -> Frame_Err one-cycle pulse, RX_Data_Valid stays 0, RX_Data keeps its previous value.
REQ-030 With RX_PARITY_EN, payload 55'h3 sent with parity bit 1 -> Frame_Err pulse, no valid. With parity 0 -> valid, RX_Data = 55'h3.
REQ-031 Rst pulsed at data bit 30, then a full frame 55'h7F -> no Frame_Err, one valid word = 55'h7F.
